mem_arbiter: RTL and testbench

- Arbitrates between the pipeline's instruction-fetch port and data-memory port for one shared single-ported unified memory with variable latency.
- Each pipeline port sees a request/ready handshake; the pipeline derives its stall signals from it (stall IF while if_req & ~if_ready, stall MEM likewise).
- Data accesses have priority.
- A starvation counter guarantees instruction fetch progress.
- A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data ports: data has priority, fetch is protected from starvation, and a watchdog aborts stuck accesses.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              grant_dm
);
  localparam int SC_W = $clog2(MAX_STARVE + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(MAX_STARVE);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUS_IF = 2'd1,
    BUS_DM = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [SC_W-1:0]   starve_cnt_r, starve_cnt_s;
  logic [WD_W-1:0]   wd_cnt_r, wd_cnt_s;
  logic              mem_req_s, mem_we_s, if_ready_s, dm_ready_s, err_s, grant_dm_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s, if_rdata_s, dm_rdata_s;
  logic              if_elig_s, dm_elig_s;

  // A requester is not eligible in its own ready cycle, so a completed request is never re-granted.
  assign if_elig_s = if_req & ~if_ready;
  assign dm_elig_s = dm_req & ~dm_ready;

  // Next-state, arbitration, watchdog and next-output logic.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    wd_cnt_s     = wd_cnt_r;
    mem_req_s    = mem_req;
    mem_we_s     = mem_we;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    if_rdata_s   = if_rdata;
    dm_rdata_s   = dm_rdata;
    grant_dm_s   = grant_dm;
    if_ready_s   = 1'b0;
    dm_ready_s   = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_elig_s && (!if_elig_s || (starve_cnt_r < STARVE_MAX))) begin
          state_s     = BUS_DM;
          mem_req_s   = 1'b1;
          mem_we_s    = dm_we;
          mem_addr_s  = dm_addr;
          mem_wdata_s = dm_wdata;
          grant_dm_s  = 1'b1;
          wd_cnt_s    = {WD_W{1'b0}};
          if (if_elig_s) begin
            starve_cnt_s = starve_cnt_r + SC_W'(1'b1);
          end else begin
            starve_cnt_s = {SC_W{1'b0}};
          end
        end else if (if_elig_s) begin
          state_s      = BUS_IF;
          mem_req_s    = 1'b1;
          mem_we_s     = 1'b0;
          mem_addr_s   = if_addr;
          grant_dm_s   = 1'b0;
          wd_cnt_s     = {WD_W{1'b0}};
          starve_cnt_s = {SC_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BUS_IF, BUS_DM: begin
        if (mem_ack) begin
          state_s   = IDLE;
          mem_req_s = 1'b0;
          if (state_r == BUS_IF) begin
            if_ready_s = 1'b1;
            if_rdata_s = mem_rdata;
          end else begin
            dm_ready_s = 1'b1;
            if (!mem_we) begin
              dm_rdata_s = mem_rdata;
            end else begin
              dm_rdata_s = dm_rdata;
            end
          end
        end else if (wd_cnt_r == WD_LAST) begin
          // Abort: complete the owner with all-ones data so the pipeline cannot hang.
          state_s   = IDLE;
          mem_req_s = 1'b0;
          err_s     = 1'b1;
          if (state_r == BUS_IF) begin
            if_ready_s = 1'b1;
            if_rdata_s = {DATA_W{1'b1}};
          end else begin
            dm_ready_s = 1'b1;
            dm_rdata_s = {DATA_W{1'b1}};
          end
        end else begin
          wd_cnt_s = wd_cnt_r + WD_W'(1'b1);
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= {SC_W{1'b0}};
      wd_cnt_r     <= {WD_W{1'b0}};
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      if_rdata     <= {DATA_W{1'b0}};
      dm_rdata     <= {DATA_W{1'b0}};
      if_ready     <= 1'b0;
      dm_ready     <= 1'b0;
      err          <= 1'b0;
      grant_dm     <= 1'b0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      wd_cnt_r     <= wd_cnt_s;
      mem_req      <= mem_req_s;
      mem_we       <= mem_we_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      if_rdata     <= if_rdata_s;
      dm_rdata     <= dm_rdata_s;
      if_ready     <= if_ready_s;
      dm_ready     <= dm_ready_s;
      err          <= err_s;
      grant_dm     <= grant_dm_s;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level arbitration model
// predicts each grant and its completion; a negedge monitor checks every ready pulse.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MS = 3, TO = 15, NEVER = 1000;

  logic          clk = 1'b0, reset;
  logic          if_req, if_ready, dm_req, dm_we, dm_ready;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, err, grant_dm;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .grant_dm(grant_dm)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    logic [DW-1:0] rdata;
    bit          err;
    int          cyc;
  } resp_t;
  resp_t exp_q[$];

  int tests = 0, fails = 0, cyc = 0;
  bit prev_idle, prev_if_elig, prev_dm_elig, in_bus, own_dm, cur_we, force_never;
  bit if_pend, dm_pend, if_granted, dm_granted;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, last_dm, plan_rdata, exp_mem_wdata;
  int starve, start_cyc, end_cyc, delay;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pick_delay();
    int r = $urandom_range(0, 9);
    if (force_never) return NEVER;
    case (r)
      0, 1, 2, 3, 4: return $urandom_range(0, 3);
      5: return TO - 1;
      6: return TO - 2;
      7: return NEVER;
      default: return $urandom_range(4, 8);
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    prev_idle = 1'b1; prev_if_elig = 1'b0; prev_dm_elig = 1'b0;
    in_bus = 1'b0; starve = 0; last_dm = '0; exp_mem_wdata = '0;
    if_pend = 1'b0; dm_pend = 1'b0; if_granted = 1'b0; dm_granted = 1'b0;
  endtask

  // mode 0: random traffic, 1: DM saturating while IF backs off in DM ready cycles, 2: no new requests
  task automatic step(input int mode);
    bit exp_req, exp_dm, want_if, want_dm;
    resp_t e;
    int wd;
    @(posedge clk); #1; cyc++;
    if (prev_idle) begin
      exp_req = prev_if_elig | prev_dm_elig;
      chk("mem_req_after_idle", mem_req, exp_req);
      if (mem_req && exp_req) begin
        exp_dm = prev_dm_elig && (!prev_if_elig || starve < MS);
        chk("grant_dm", grant_dm, exp_dm);
        own_dm = exp_dm;
        if (exp_dm) begin
          cur_addr = dm_addr; cur_we = dm_we; cur_wdata = dm_wdata;
          exp_mem_wdata = dm_wdata;
          starve = prev_if_elig ? starve + 1 : 0;
          dm_granted = 1'b1;
        end else begin
          cur_addr = if_addr; cur_we = 1'b0; cur_wdata = exp_mem_wdata;
          starve = 0;
          if_granted = 1'b1;
        end
        delay = pick_delay();
        plan_rdata = $urandom;
        start_cyc = cyc;
        in_bus = 1'b1;
        e.is_dm = own_dm;
        e.err = (delay >= TO);
        e.rdata = e.err ? {DW{1'b1}} : ((own_dm && cur_we) ? last_dm : plan_rdata);
        e.cyc = e.err ? start_cyc + TO : start_cyc + delay + 1;
        if (own_dm) last_dm = e.rdata;
        end_cyc = e.cyc;
        exp_q.push_back(e);
      end
    end
    if (in_bus) begin
      chk("mem_req_in_bus", mem_req, cyc < end_cyc);
      if (cyc >= end_cyc) begin
        in_bus = 1'b0;
      end else if (mem_req) begin
        chk("mem_addr", mem_addr, cur_addr);
        chk("mem_we", mem_we, cur_we);
        chk("mem_wdata", mem_wdata, cur_wdata);
      end
    end
    // Memory model: ack after the planned number of bus cycles; stray acks while idle.
    if (in_bus) begin
      wd = cyc - start_cyc;
      mem_ack = (wd == delay);
      mem_rdata = (wd == delay) ? plan_rdata : $urandom;
    end else begin
      mem_ack = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    if (if_ready) begin if_pend = 1'b0; if_granted = 1'b0; end
    if (dm_ready) begin dm_pend = 1'b0; dm_granted = 1'b0; end
    want_if = (mode == 1) || (mode == 0 && $urandom_range(0, 2) == 0);
    want_dm = (mode == 1) || (mode == 0 && $urandom_range(0, 1) == 0);
    if (if_granted) begin
      if_addr = $urandom;
    end else if (!if_pend && want_if) begin
      if_pend = 1'b1; if_addr = $urandom;
    end
    if (dm_granted) begin
      dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1);
    end else if (!dm_pend && want_dm) begin
      dm_pend = 1'b1; dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(0, 1);
    end
    if_req = if_pend && !(mode == 1 && dm_ready && !if_granted);
    dm_req = dm_pend;
    prev_idle = !mem_req;
    prev_if_elig = if_req && !if_ready;
    prev_dm_elig = dm_req && !dm_ready;
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest predicted response.
  always @(negedge clk) begin : monitor
    resp_t e;
    if (!reset) begin
      chk("err_only_with_ready", err & ~(if_ready | dm_ready), 1'b0);
      if (if_ready || dm_ready) begin
        chk("single_ready", if_ready & dm_ready, 1'b0);
        chk("ready_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_port_dm", dm_ready, e.is_dm);
          chk("resp_rdata", dm_ready ? dm_rdata : if_rdata, e.rdata);
          chk("resp_err", err, e.err);
          chk("resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    force_never = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_outputs", {mem_we, if_ready, dm_ready, err, grant_dm}, 5'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_rdata", {if_rdata, dm_rdata, mem_wdata}, '0);
    reset = 1'b0;

    repeat (1500) step(0);
    repeat (400) step(1);
    repeat (40) step(2);
    chk("drained_phase1", exp_q.size(), 0);

    // Asynchronous reset between clock edges while a data read is in flight.
    force_never = 1'b1;
    dm_pend = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    prev_dm_elig = !dm_ready;
    for (int i = 0; i < 10 && !(in_bus && own_dm); i++) step(2);
    chk("reached_bus_dm", in_bus && own_dm, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_dm_ready", dm_ready, 1'b0);
    chk("async_rst_grant_dm", grant_dm, 1'b0);
    dm_req = 1'b0; if_req = 1'b0;
    #2 reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    force_never = 1'b0;
    model_reset();
    repeat (5) step(2);
    chk("late_ack_dm_rdata", dm_rdata, '0);

    repeat (500) step(0);
    repeat (40) step(2);
    chk("drained_phase2", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
